// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment time display.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned BUS_W  = 22;

   typedef logic [1:0] scan_idx_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/seg7_time_display_bcd.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show a dash.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_time_display.sv
// Multiplexed 4-digit common-anode driver for HH:MM with blinking colon and set-mode blink.
// Define LEADING_ZERO_BLANK_EN to suppress a zero hour-tens digit.
module seg7_time_display
   import seg7_pkg::*;
#(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLANK_CYCLES = 16,
   parameter int unsigned BLINK_DIV    = 25000000
) (
   input  logic              clk_100MHz,
   input  logic              reset,
   input  logic [3:0]        hr_10s,
   input  logic [3:0]        hr_1s,
   input  logic [3:0]        min_10s,
   input  logic [3:0]        min_1s,
   input  logic [5:0]        sec,
   input  logic              blink_en,
   output logic [DIGITS-1:0] an,
   output logic [6:0]        seg,
   output logic              dp
);

   localparam int unsigned SlotW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [SlotW-1:0]  SlotLast  = SlotW'(REFRESH_DIV - 1);
   localparam logic [SlotW-1:0]  BlankEnd  = SlotW'(BLANK_CYCLES);
   localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

   logic [BUS_W-1:0]  bus_in, sync_s1, sync_s2, disp_q, disp_d;
   logic [SlotW-1:0]  slot_cnt_q, slot_cnt_d;
   scan_idx_t         idx_q, idx_d;
   logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
   logic              blink_phase_q, blink_phase_d;
   logic [DIGITS-1:0] an_d;
   logic              dp_d;
   logic              slot_last, frame_wrap, stable, blanked, visible;
   logic [3:0]        digit;
   logic [6:0]        digit_seg;

   assign bus_in     = {hr_10s, hr_1s, min_10s, min_1s, sec};
   assign slot_last  = (slot_cnt_q == SlotLast);
   assign frame_wrap = slot_last && (idx_q == 2'd3);
   assign stable     = (sync_s1 == sync_s2);
   assign blanked    = (slot_cnt_q < BlankEnd);
   // Gated by the live blink_en so dropping set mode is visible on the very next output.
   assign visible    = !(blink_en && blink_phase_q);

   always_comb begin
      slot_cnt_d    = slot_last ? '0 : slot_cnt_q + 1'b1;
      idx_d         = slot_last ? idx_q + 2'd1 : idx_q;
      disp_d        = (frame_wrap && stable) ? sync_s2 : disp_q;
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
      if (blink_en) begin
         if (blink_cnt_q == BlinkLast) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d   = blink_cnt_q + 1'b1;
            blink_phase_d = blink_phase_q;
         end
      end
   end

   always_comb begin
      digit = disp_q[9:6];
      unique case (idx_q)
         2'd0: digit = disp_q[9:6];
         2'd1: digit = disp_q[13:10];
         2'd2: digit = disp_q[17:14];
         2'd3: digit = disp_q[21:18];
         default: digit = disp_q[9:6];
      endcase
   end

   bcd_to_seg7 u_dec (
      .bcd (digit),
      .seg (digit_seg)
   );

   always_comb begin
      an_d = '1;
      if (!blanked && visible) begin
         an_d[idx_q] = 1'b0;
      end
`ifdef LEADING_ZERO_BLANK_EN
      if ((idx_q == 2'd3) && (disp_q[21:18] == 4'd0)) begin
         an_d = '1;
      end
`endif
      // Colon lit on even seconds of the latched frame.
      dp_d = !((idx_q == 2'd2) && !blanked && visible && !disp_q[0]);
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         sync_s1       <= '0;
         sync_s2       <= '0;
         disp_q        <= '0;
         slot_cnt_q    <= '0;
         idx_q         <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         an            <= '1;
         seg           <= SEG_BLANK;
         dp            <= 1'b1;
      end else begin
         sync_s1       <= bus_in;
         sync_s2       <= sync_s1;
         disp_q        <= disp_d;
         slot_cnt_q    <= slot_cnt_d;
         idx_q         <= idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         an            <= an_d;
         seg           <= digit_seg;
         dp            <= dp_d;
      end
   end

endmodule
